fir_coeff_ctrl: RTL and testbench
=================================

Name: fir_coeff_ctrl

Overview:
Run-time coefficient controller for the MSO FIR datapath. Accepts per-tap coefficient writes into a shadow bank over a valid/ready port. On request, atomically swaps the shadow bank into the active bank that drives the filter's packed coefficient bus. Then masks filter output for the pipeline refill window, so downstream capture never sees mixed old/new-coefficient samples.

Parameters:
COEFF_WIDTH, 8, signed coefficient width in bits.
NUM_TAPS, 4, number of filter taps (>=2, need not be a power of 2).
IDX_WIDTH, clog2(NUM_TAPS) (min 1), tap index width.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
cfg_valid  in  1  coefficient write request.
cfg_ready  out  1  controller can accept a write.
cfg_index  in  IDX_WIDTH  tap number for the write.
cfg_coeff  in  COEFF_WIDTH  signed coefficient value.
commit_req  in  1  single-cycle strobe: swap shadow into active.
commit_done  out  1  single-cycle pulse: swap complete and filter refilled.
packed_coeff  out  NUM_TAPS*COEFF_WIDTH  active bank to FIR; tap i at bits [COEFF_WIDTH*(i+1)-1 : COEFF_WIDTH*i].
out_valid  out  1  FIR output qualifier; low while pipeline holds stale taps.
shadow_dirty  out  1  shadow bank differs from last commit.
cfg_err  out  1  sticky: write with cfg_index >= NUM_TAPS was dropped.

Behaviour:
- States: IDLE, SWAP, SETTLE. A down-counter cnt sized for NUM_TAPS is used in SETTLE.
- Reset values:
  - state = SETTLE, cnt = NUM_TAPS.
  - active bank = tap0 = +1, all other taps 0 (passthrough). Shadow bank = all 0.
  - cfg_ready = 0, commit_done = 0, out_valid = 0, shadow_dirty = 0, cfg_err = 0, pending = 0.
- After reset release, the block settles for NUM_TAPS cycles, then enters IDLE with commit_done = 0 (no pulse after reset).
- IDLE:
  - cfg_ready = 1 and out_valid = 1.
  - On cfg_valid & cfg_ready with cfg_index < NUM_TAPS: shadow[cfg_index] <= cfg_coeff and shadow_dirty <= 1. Visible in shadow the next cycle.
  - With an index out of range: write dropped, cfg_err <= 1. Cleared only by reset.
  - commit_req (or pending = 1) moves to SWAP and clears pending.
  - A write and commit_req in the same cycle: the write is included in the commit.
- SWAP (1 cycle):
  - cfg_ready = 0, out_valid = 0.
  - At the exiting edge: active <= shadow, shadow_dirty <= 0, cnt <= NUM_TAPS. Go to SETTLE.
  - packed_coeff changes exactly on this edge.
- SETTLE:
  - cfg_ready = 0, out_valid = 0, cnt decrements each cycle.
  - When cnt == 1, the next state is IDLE and commit_done is registered high for exactly the first IDLE cycle, coincident with out_valid rising.
- commit_req in SWAP/SETTLE sets pending (multiple requests collapse to one). On entry to IDLE with pending = 1, the block goes straight back to SWAP after one IDLE cycle. out_valid and commit_done are high in that cycle.
- cfg_valid while cfg_ready = 0 is not accepted. The master holds it; no data is lost.
- Commit latency: commit_req sampled at edge E0 → packed_coeff updates at E1 → out_valid low for NUM_TAPS+1 cycles total → commit_done at cycle NUM_TAPS+2 after E0.
- Commit with shadow_dirty = 0 is still a full swap and settle (idempotent).
- Reset mid-SWAP/SETTLE: immediate return to reset values. Both banks revert, pending is lost.
- No arithmetic on coefficients: bit-exact copy, sign preserved.
- All outputs are registered.

Decomposition:
- Package mso_fir_pkg: state encoding (IDLE/SWAP/SETTLE), clog2 function, reset-coefficient constant (identity tap vector builder).
- One natural sub-module, fir_coeff_bank: shadow and active registers with indexed write, swap strobe, and packed output.
- The FSM, counter, and pending/err flags stay in fir_coeff_ctrl.

Test Plan:
- Reset, release, hold idle:
  - out_valid = 0 for 4 cycles after release, then 1.
  - packed_coeff = 32'h0000_0001; commit_done never pulses.
- Write taps 0..3 = -2, -1, 3, 4, then commit_req:
  - packed_coeff = 32'h0403_FFFE one cycle after the commit edge.
  - out_valid low 5 cycles; commit_done one pulse; shadow_dirty 1→0.
- Write tap 2 = 7 and commit_req in the same cycle: committed bus has tap2 = 8'h07.
- commit_req twice during SETTLE with a new write queued:
  - cfg_ready held 0 during SETTLE; the queued write completes in the IDLE gap.
  - Exactly one extra swap follows, and it includes that write; two commit_done pulses total.
- Write with cfg_index = 3 when NUM_TAPS = 3:
  - Write dropped, cfg_err = 1 sticky, shadow unchanged, shadow_dirty unchanged.
- Assert rst_n low two cycles into SETTLE after committing 32'h0403_FFFE:
  - packed_coeff returns asynchronously to 32'h0000_0001; outputs at reset values; refill restarts on release.

Source files
------------

// File: rtl/mso_fir_pkg.sv
// Shared types and helpers for the MSO FIR coefficient controller.
// Holds the controller state encoding, a width helper and the reset tap values.
package mso_fir_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSwap,
        StSettle
    } fir_state_e;

    // Ceiling log2 with a floor of 1, so even a 1-entry range gets a real bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Builds the passthrough tap vector one tap at a time: tap 0 = +1, others 0.
    function automatic int unsigned identity_tap(input int unsigned tap);
        return (tap == 0) ? 1 : 0;
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow and active coefficient banks: indexed writes land in shadow,
// a swap strobe copies the whole shadow bank into active in one edge.
module fir_coeff_bank
    import mso_fir_pkg::*;
#(
    parameter int unsigned COEFF_WIDTH = 8,
    parameter int unsigned NUM_TAPS    = 4,
    parameter int unsigned IDX_WIDTH   = clog2(NUM_TAPS)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            wr_en_i,
    input  logic [IDX_WIDTH-1:0]            wr_idx_i,
    input  logic [COEFF_WIDTH-1:0]          wr_coeff_i,
    input  logic                            swap_i,
    output logic [NUM_TAPS*COEFF_WIDTH-1:0] packed_coeff_o
);

    logic [COEFF_WIDTH-1:0] shadow_q [NUM_TAPS];
    logic [COEFF_WIDTH-1:0] active_q [NUM_TAPS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_TAPS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= COEFF_WIDTH'(identity_tap(i));
            end
        end else begin
            for (int unsigned i = 0; i < NUM_TAPS; i++) begin
                if (wr_en_i && (wr_idx_i == IDX_WIDTH'(i))) begin
                    shadow_q[i] <= wr_coeff_i;
                end
                if (swap_i) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    always_comb begin
        packed_coeff_o = '0;
        for (int unsigned i = 0; i < NUM_TAPS; i++) begin
            packed_coeff_o[COEFF_WIDTH*i +: COEFF_WIDTH] = active_q[i];
        end
    end

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Run-time FIR coefficient controller: accepts shadow writes, swaps banks on
// commit and masks filter output while the pipeline refills with new taps.
module fir_coeff_ctrl
    import mso_fir_pkg::*;
#(
    parameter int unsigned COEFF_WIDTH = 8,
    parameter int unsigned NUM_TAPS    = 4,
    parameter int unsigned IDX_WIDTH   = clog2(NUM_TAPS)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            cfg_valid_i,
    output logic                            cfg_ready_o,
    input  logic [IDX_WIDTH-1:0]            cfg_index_i,
    input  logic [COEFF_WIDTH-1:0]          cfg_coeff_i,
    input  logic                            commit_req_i,
    output logic                            commit_done_o,
    output logic [NUM_TAPS*COEFF_WIDTH-1:0] packed_coeff_o,
    output logic                            out_valid_o,
    output logic                            shadow_dirty_o,
    output logic                            cfg_err_o
);

    localparam int unsigned CNT_WIDTH = clog2(NUM_TAPS + 1);

    fir_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 pending_q, pending_d;
    logic                 done_arm_q, done_arm_d;
    logic                 cfg_ready_q, cfg_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 commit_done_q, commit_done_d;
    logic                 shadow_dirty_q, shadow_dirty_d;
    logic                 cfg_err_q, cfg_err_d;

    logic accept, in_range, wr_en, swap;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pending_d      = pending_q;
        done_arm_d     = done_arm_q;
        commit_done_d  = 1'b0;
        swap           = 1'b0;

        // cfg_ready_q is high exactly in IDLE, so it gates acceptance directly.
        accept         = cfg_valid_i & cfg_ready_q;
        in_range       = 32'(cfg_index_i) < NUM_TAPS;
        wr_en          = accept & in_range;
        cfg_err_d      = cfg_err_q | (accept & ~in_range);
        shadow_dirty_d = shadow_dirty_q | wr_en;

        case (state_q)
            StIdle: begin
                if (commit_req_i || pending_q) begin
                    state_d   = StSwap;
                    pending_d = 1'b0;
                end
            end
            StSwap: begin
                swap           = 1'b1;
                shadow_dirty_d = 1'b0;
                cnt_d          = CNT_WIDTH'(NUM_TAPS);
                done_arm_d     = 1'b1;
                pending_d      = pending_q | commit_req_i;
                state_d        = StSettle;
            end
            StSettle: begin
                cnt_d     = cnt_q - CNT_WIDTH'(1);
                pending_d = pending_q | commit_req_i;
                // done_arm_q stays clear through the post-reset settle, so no pulse then.
                if (cnt_q <= CNT_WIDTH'(1)) begin
                    state_d       = StIdle;
                    commit_done_d = done_arm_q;
                    done_arm_d    = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        cfg_ready_d = (state_d == StIdle);
        out_valid_d = (state_d == StIdle);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StSettle;
            cnt_q          <= CNT_WIDTH'(NUM_TAPS);
            pending_q      <= 1'b0;
            done_arm_q     <= 1'b0;
            cfg_ready_q    <= 1'b0;
            out_valid_q    <= 1'b0;
            commit_done_q  <= 1'b0;
            shadow_dirty_q <= 1'b0;
            cfg_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pending_q      <= pending_d;
            done_arm_q     <= done_arm_d;
            cfg_ready_q    <= cfg_ready_d;
            out_valid_q    <= out_valid_d;
            commit_done_q  <= commit_done_d;
            shadow_dirty_q <= shadow_dirty_d;
            cfg_err_q      <= cfg_err_d;
        end
    end

    fir_coeff_bank #(
        .COEFF_WIDTH(COEFF_WIDTH),
        .NUM_TAPS   (NUM_TAPS),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_bank (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .wr_en_i       (wr_en),
        .wr_idx_i      (cfg_index_i),
        .wr_coeff_i    (cfg_coeff_i),
        .swap_i        (swap),
        .packed_coeff_o(packed_coeff_o)
    );

    assign cfg_ready_o    = cfg_ready_q;
    assign out_valid_o    = out_valid_q;
    assign commit_done_o  = commit_done_q;
    assign shadow_dirty_o = shadow_dirty_q;
    assign cfg_err_o      = cfg_err_q;

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Self-checking bench for fir_coeff_ctrl: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_fir_coeff_ctrl;

    localparam int unsigned N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid, commit_req;
    logic [1:0]  cfg_index;
    logic [7:0]  cfg_coeff;
    logic        cfg_ready, commit_done, out_valid, shadow_dirty, cfg_err;
    logic [31:0] packed_coeff;

    logic        d3_valid, d3_commit;
    logic [1:0]  d3_index;
    logic [7:0]  d3_coeff;
    logic        d3_ready, d3_done, d3_ov, d3_dirty, d3_err;
    logic [23:0] d3_packed;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fir_coeff_ctrl #(.COEFF_WIDTH(8), .NUM_TAPS(4)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .cfg_index_i(cfg_index), .cfg_coeff_i(cfg_coeff),
        .commit_req_i(commit_req), .commit_done_o(commit_done),
        .packed_coeff_o(packed_coeff), .out_valid_o(out_valid),
        .shadow_dirty_o(shadow_dirty), .cfg_err_o(cfg_err)
    );

    fir_coeff_ctrl #(.COEFF_WIDTH(8), .NUM_TAPS(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_valid_i(d3_valid), .cfg_ready_o(d3_ready),
        .cfg_index_i(d3_index), .cfg_coeff_i(d3_coeff),
        .commit_req_i(d3_commit), .commit_done_o(d3_done),
        .packed_coeff_o(d3_packed), .out_valid_o(d3_ov),
        .shadow_dirty_o(d3_dirty), .cfg_err_o(d3_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: busy counts remaining masked cycles; 0 means idle.
    logic [7:0] m_shadow [N];
    logic [7:0] m_active [N];
    int         m_busy;
    bit         m_swap_next, m_pend, m_from_commit, m_done, m_dirty, m_err;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_shadow[i] = 8'h00;
            m_active[i] = (i == 0) ? 8'h01 : 8'h00;
        end
        m_busy = N; m_swap_next = 0; m_pend = 0; m_from_commit = 0;
        m_done = 0; m_dirty = 0; m_err = 0;
    endfunction

    function automatic logic [31:0] m_packed();
        logic [31:0] r;
        for (int i = 0; i < N; i++) r[8*i +: 8] = m_active[i];
        return r;
    endfunction

    function automatic void model_step();
        if (m_busy == 0) begin
            m_done = 0;
            if (cfg_valid) begin
                if (int'(cfg_index) < N) begin
                    m_shadow[cfg_index] = cfg_coeff;
                    m_dirty = 1;
                end else begin
                    m_err = 1;
                end
            end
            if (commit_req || m_pend) begin
                m_pend = 0; m_busy = N + 1; m_swap_next = 1; m_from_commit = 1;
            end
        end else begin
            if (commit_req) m_pend = 1;
            if (m_swap_next) begin
                for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
                m_dirty = 0; m_swap_next = 0;
            end
            m_busy--;
            m_done = (m_busy == 0) && m_from_commit;
            if (m_busy == 0) m_from_commit = 0;
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("packed_coeff", packed_coeff, m_packed());
        chk("out_valid", out_valid, m_busy == 0);
        chk("cfg_ready", cfg_ready, m_busy == 0);
        chk("commit_done", commit_done, m_done);
        chk("shadow_dirty", shadow_dirty, m_dirty);
        chk("cfg_err", cfg_err, m_err);
    endtask

    task automatic check_reset_values();
        chk("rst_packed", packed_coeff, 32'h0000_0001);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_commit_done", commit_done, 0);
        chk("rst_shadow_dirty", shadow_dirty, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_d3_packed", d3_packed, 24'h00_0001);
    endtask

    typedef struct {
        bit          valid;
        logic [1:0]  idx;
        logic [7:0]  coeff;
        bit          commit;
        logic [31:0] e_packed;
        bit          e_ov;
        bit          e_done;
        bit          e_dirty;
    } vec_t;

    vec_t vt [11];

    initial begin
        int lows, dones, k;
        bit acc;

        vt[0]  = '{1, 2'd0, 8'hFE, 0, 32'h0000_0001, 1, 0, 1};
        vt[1]  = '{1, 2'd1, 8'hFF, 0, 32'h0000_0001, 1, 0, 1};
        vt[2]  = '{1, 2'd2, 8'h03, 0, 32'h0000_0001, 1, 0, 1};
        vt[3]  = '{1, 2'd3, 8'h04, 0, 32'h0000_0001, 1, 0, 1};
        vt[4]  = '{0, 2'd0, 8'h00, 1, 32'h0000_0001, 0, 0, 1};
        vt[5]  = '{0, 2'd0, 8'h00, 0, 32'h0403_FFFE, 0, 0, 0};
        vt[6]  = '{0, 2'd0, 8'h00, 0, 32'h0403_FFFE, 0, 0, 0};
        vt[7]  = '{0, 2'd0, 8'h00, 0, 32'h0403_FFFE, 0, 0, 0};
        vt[8]  = '{0, 2'd0, 8'h00, 0, 32'h0403_FFFE, 0, 0, 0};
        vt[9]  = '{0, 2'd0, 8'h00, 0, 32'h0403_FFFE, 1, 1, 0};
        vt[10] = '{0, 2'd0, 8'h00, 0, 32'h0403_FFFE, 1, 0, 0};

        cfg_valid = 0; commit_req = 0; cfg_index = 0; cfg_coeff = 0;
        d3_valid = 0; d3_commit = 0; d3_index = 0; d3_coeff = 0;
        model_reset();

        // Reset, release, hold idle.
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1;
        lows = 0; dones = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (!out_valid) lows++;
            if (commit_done) dones++;
        end
        // The partial cycle before the first edge is also masked, giving 4 in all.
        chk("boot_lows_after_edges", lows, 3);
        chk("boot_no_done", dones, 0);
        chk("boot_packed", packed_coeff, 32'h0000_0001);

        // Directed write-and-commit table.
        for (int i = 0; i < 11; i++) begin
            cfg_valid = vt[i].valid; cfg_index = vt[i].idx;
            cfg_coeff = vt[i].coeff; commit_req = vt[i].commit;
            cycle();
            chk($sformatf("vec%0d_packed", i), packed_coeff, vt[i].e_packed);
            chk($sformatf("vec%0d_out_valid", i), out_valid, vt[i].e_ov);
            chk($sformatf("vec%0d_done", i), commit_done, vt[i].e_done);
            chk($sformatf("vec%0d_dirty", i), shadow_dirty, vt[i].e_dirty);
        end
        cfg_valid = 0; commit_req = 0;

        // Write and commit in the same cycle.
        cfg_valid = 1; cfg_index = 2; cfg_coeff = 8'h07; commit_req = 1;
        cycle();
        cfg_valid = 0; commit_req = 0;
        cycle();
        chk("same_cycle_tap2", packed_coeff[23:16], 8'h07);
        chk("same_cycle_bus", packed_coeff, 32'h0407_FFFE);
        repeat (6) cycle();

        // Two commits during SETTLE with a write held until accepted.
        dones = 0;
        for (k = 0; k < 25; k++) begin
            commit_req = (k == 0) || (k == 2) || (k == 4);
            if (k == 1) begin
                cfg_valid = 1; cfg_index = 1; cfg_coeff = 8'h05;
            end
            acc = cfg_valid && cfg_ready;
            if (cfg_valid && k > 0 && k < 5) chk("held_ready_low", cfg_ready, 0);
            cycle();
            if (acc) cfg_valid = 0;
            if (commit_done) dones++;
        end
        commit_req = 0;
        chk("pending_done_pulses", dones, 2);
        chk("pending_bus", packed_coeff, 32'h0407_05FE);
        chk("pending_dirty", shadow_dirty, 0);

        // Reset two cycles into SETTLE after committing 0403FFFE.
        cfg_valid = 1; cfg_index = 1; cfg_coeff = 8'hFF; cycle();
        cfg_index = 2; cfg_coeff = 8'h03; cycle();
        cfg_valid = 0; commit_req = 1; cycle();
        commit_req = 0; cycle();
        cycle();
        cycle();
        chk("pre_reset_bus", packed_coeff, 32'h0403_FFFE);
        #2;
        rst_n = 0;
        #1;
        check_reset_values();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (!out_valid) lows++;
        end
        chk("rerst_lows_after_edges", lows, 3);
        chk("rerst_bus", packed_coeff, 32'h0000_0001);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cfg_valid  = 1'($urandom_range(0, 1));
            cfg_index  = 2'($urandom_range(0, 3));
            cfg_coeff  = 8'($urandom);
            commit_req = ($urandom_range(0, 9) == 0);
            cycle();
        end
        cfg_valid = 0; commit_req = 0;
        repeat (8) cycle();

        // Out-of-range write on the 3-tap instance.
        chk("d3_idle", d3_ready, 1);
        chk("d3_err_clear", d3_err, 0);
        d3_valid = 1; d3_index = 1; d3_coeff = 8'h55; cycle();
        chk("d3_dirty_set", d3_dirty, 1);
        d3_index = 3; d3_coeff = 8'h7F; cycle();
        chk("d3_err_set", d3_err, 1);
        chk("d3_dirty_kept", d3_dirty, 1);
        d3_valid = 0; d3_commit = 1; cycle();
        d3_commit = 0; cycle();
        chk("d3_bus_unchanged", d3_packed, 24'h00_5500);
        repeat (6) cycle();
        chk("d3_err_sticky", d3_err, 1);
        chk("d3_dirty_cleared", d3_dirty, 0);
        chk("d3_back_idle", d3_ov, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
